// File: rtl/mac_pkg.sv
// Shared constants for the signed multiply / multiply-accumulate unit.
package mac_pkg;

  localparam int unsigned MAC_DATA_W = 32;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_MAC = 1'b1;

  // Signed saturation bounds at the default width.
  localparam logic [MAC_DATA_W-1:0] SAT_MAX = {1'b0, {(MAC_DATA_W-1){1'b1}}};
  localparam logic [MAC_DATA_W-1:0] SAT_MIN = {1'b1, {(MAC_DATA_W-1){1'b0}}};

endpackage

// File: rtl/mac_mult.sv
// Combinational signed DATA_W x DATA_W multiplier producing the full 2*DATA_W product.
module mac_mult
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] p
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  // Sign-extend both operands first so the product keeps its full width.
  assign p = PROD_W'(a) * PROD_W'(b);

endmodule

// File: rtl/mac_unit.sv
// Signed multiply / multiply-accumulate unit; o is the accumulator register.
// Optional build macro SATURATE_EN: saturate product load and accumulate instead of wrapping.
module mac_unit
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W = MAC_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              en,
  input  logic              mul_mac_signal,
  output logic [DATA_W-1:0] o
);

  localparam int unsigned PROD_W = 2 * DATA_W;

  logic [PROD_W-1:0] prod;
  logic [DATA_W-1:0] acc_nxt;

  mac_mult #(.DATA_W(DATA_W)) u_mult (
    .a (a),
    .b (b),
    .p (prod)
  );

`ifdef SATURATE_EN
  localparam logic [DATA_W-1:0] SAT_HI = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SAT_LO = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] prod_sat;
  logic [DATA_W-1:0] sum;
  logic              prod_ovf;
  logic              sum_ovf;

  // Clamp the product first, then clamp the accumulate on signed add overflow.
  always_comb begin
    prod_ovf = (prod[PROD_W-1:DATA_W-1] != {(DATA_W+1){prod[PROD_W-1]}});
    prod_sat = prod[DATA_W-1:0];
    if (prod_ovf) begin
      prod_sat = prod[PROD_W-1] ? SAT_LO : SAT_HI;
    end
    sum     = o + prod_sat;
    sum_ovf = (o[DATA_W-1] == prod_sat[DATA_W-1]) && (sum[DATA_W-1] != o[DATA_W-1]);
    acc_nxt = prod_sat;
    if (mul_mac_signal == MODE_MAC) begin
      acc_nxt = sum;
      if (sum_ovf) begin
        acc_nxt = o[DATA_W-1] ? SAT_LO : SAT_HI;
      end
    end
  end
`else
  // Only the low product slice matters when wrapping.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[PROD_W-1:DATA_W];

  always_comb begin
    acc_nxt = o + prod[DATA_W-1:0];
    if (mul_mac_signal == MODE_MUL) begin
      acc_nxt = prod[DATA_W-1:0];
    end
  end
`endif

  // Accumulator: reset wins over en; holds while en is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      o <= '0;
    end else if (en) begin
      o <= acc_nxt;
    end
  end

endmodule

// File: tb/tb_mac_unit.sv
// Scoreboard bench for mac_unit: directed cases plus random ops against an integer reference model.
module tb_mac_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         en;
  logic         mul_mac_signal;
  logic [W-1:0] o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  longint       acc_m;

  mac_unit #(.DATA_W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .a              (a),
    .b              (b),
    .en             (en),
    .mul_mac_signal (mul_mac_signal),
    .o              (o)
  );

  always #5 clk = ~clk;

  // Reduce an exact integer result to the 32-bit signed range of the build.
  function automatic longint fit(input longint v);
`ifdef SATURATE_EN
    if (v > 64'sd2147483647) return 64'sd2147483647;
    if (v < -64'sd2147483648) return -64'sd2147483648;
    return v;
`else
    int t;
    t = int'(v);
    return longint'(t);
`endif
  endfunction

  // Drive one cycle of inputs and queue the accumulator value expected after the next edge.
  task automatic op(input string tag, input logic r, input logic e, input logic m,
                    input logic [W-1:0] av, input logic [W-1:0] bv);
    longint p;
    @(negedge clk);
    rst = r; en = e; mul_mac_signal = m; a = av; b = bv;
    p = fit(longint'($signed(av)) * longint'($signed(bv)));
    if (r) acc_m = 0;
    else if (e) acc_m = m ? fit(acc_m + p) : p;
    exp_q.push_back(W'(acc_m));
    tag_q.push_back(tag);
  endtask

  // Monitor: the accumulator is presented every cycle; compare just after each edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string        t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL %s: o=%h expected %h", t, o, e);
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mul_mac_signal = 1'b0; a = '0; b = '0;
    acc_m = 0;

    op("reset",      1, 0, 0, 32'd0, 32'd0);
    op("reset_hold", 0, 0, 1, 32'd5, 32'd5);
    op("reset_hold", 0, 0, 0, 32'd9, 32'd9);

    op("mac_neg",    0, 1, 1, 32'hFFFF_FFF6, 32'd1);
    op("hold",       0, 0, 1, 32'd3, 32'd3);
    op("mac_add",    0, 1, 1, 32'd1, 32'd8);

    op("mul_load",   0, 1, 0, 32'd3, 32'd4);
    op("mac_negneg", 0, 1, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFD);

    op("b2b_rst",    1, 0, 0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) op("b2b_mac", 0, 1, 1, 32'd2, 32'd5);

    op("ovf_load",   0, 1, 0, 32'h7FFF_FFFF, 32'd1);
    op("ovf_add",    0, 1, 1, 32'd1, 32'd1);
    op("ovf_mul",    0, 1, 0, 32'h0001_0000, 32'h0001_0000);
    op("neg_load",   0, 1, 0, 32'h8000_0000, 32'd1);
    op("neg_add",    0, 1, 1, 32'hFFFF_FFFF, 32'd1);
    op("neg_mul",    0, 1, 0, 32'h8000_0000, 32'd2);

    op("rst_prio",   1, 1, 1, 32'd7, 32'd7);
    op("after_rst",  0, 1, 1, 32'd1, 32'd1);

    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] av;
      logic [W-1:0] bv;
      if ($urandom_range(0, 1) == 0) begin
        av = W'($urandom_range(0, 40)) - W'(20);
        bv = W'($urandom_range(0, 40)) - W'(20);
      end else begin
        av = $urandom;
        bv = ($urandom_range(0, 2) == 0) ? $urandom : W'($urandom_range(0, 65535));
      end
      op("random", ($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
         logic'($urandom_range(0, 1)), av, bv);
    end

    @(negedge clk);
    en = 1'b0; rst = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
